// File: rtl/ascon_sbox_layer_dom.sv
// DOM-masked ASCON chi layer over the full 320-bit state: LANES columns per cycle, NCHUNK+2 edges
// from accept to out_valid, plus one edge per missing randomness beat; the result is held until out_ready.
module ascon_sbox_layer_dom #(
  parameter int D     = 2,
  parameter int LANES = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [320*(D+1)-1:0]             state_in,
  input  logic                             rnd_valid,
  output logic                             rnd_ready,
  input  logic [LANES*5*D*(D+1)/2-1:0]     rnd_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [320*(D+1)-1:0]             state_out,
  output logic                             busy
);

  localparam int S      = D + 1;
  localparam int NCHUNK = 64 / LANES;
  localparam int P      = D * (D + 1) / 2;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int ZW     = LANES * 5 * S * S;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} st_t;

  st_t              st_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q, rnd_ready_q, out_valid_q, busy_q;
  logic [320*S-1:0] work_q, work_d;
  logic [ZW-1:0]    z_q, z_d;
  logic             s1_vld_q;
  logic [CW-1:0]    s1_cnt_q;
  logic             issue;
  logic [S-1:0]     xv, nxv, av;

  assign issue = rnd_ready_q & rnd_valid;

  function automatic int pidx(input int j, input int k);
    return j * S - (j * (j + 1)) / 2 + (k - j - 1);
  endfunction

  // z_jk for lane l, row i lives at ((l*5+i)*S+j)*S+k so a share's terms are contiguous
  always_comb begin : stage1
    z_d = '0;
    xv  = '0;
    nxv = '0;
    av  = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < 5; i++) begin
        for (int s = 0; s < S; s++) begin
          xv[s]  = work_q[320*s + 64*i + int'(cnt_q)*LANES + l];
          nxv[s] = work_q[320*s + 64*((i+1)%5) + int'(cnt_q)*LANES + l] ^ (s == 0);
          av[s]  = work_q[320*s + 64*((i+2)%5) + int'(cnt_q)*LANES + l];
        end
        for (int j = 0; j < S; j++) begin
          for (int k = 0; k < S; k++) begin
            if (j == k)
              z_d[((l*5+i)*S+j)*S+k] = (nxv[j] & av[k]) ^ xv[j];
            else if (j < k)
              z_d[((l*5+i)*S+j)*S+k] = (nxv[j] & av[k]) ^ rnd_in[(l*5+i)*P + pidx(j, k)];
            else
              z_d[((l*5+i)*S+j)*S+k] = (nxv[j] & av[k]) ^ rnd_in[(l*5+i)*P + pidx(k, j)];
          end
        end
      end
    end
  end

  always_comb begin : writeback
    work_d = work_q;
    if (in_ready_q && in_valid) begin
      work_d = state_in;
    end else if (s1_vld_q) begin
      for (int j = 0; j < S; j++)
        for (int i = 0; i < 5; i++)
          for (int l = 0; l < LANES; l++)
            work_d[320*j + 64*i + int'(s1_cnt_q)*LANES + l] = ^z_q[((l*5+i)*S+j)*S +: S];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q   <= '0;
      z_q      <= '0;
      s1_vld_q <= 1'b0;
      s1_cnt_q <= '0;
    end else begin
      work_q   <= work_d;
      s1_vld_q <= issue;
      if (issue) begin
        z_q      <= z_d;
        s1_cnt_q <= cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      rnd_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          if (in_valid) begin
            st_q        <= RUN;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            rnd_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        RUN: begin
          if (rnd_valid) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              st_q        <= DRAIN;
              rnd_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          st_q        <= DONE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            st_q        <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign rnd_ready = rnd_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign state_out = work_q;

endmodule

// File: tb/tb_ascon_sbox_layer_dom.sv
// Bench for the masked chi layer: three parameter sets, vector table, random masking, stall, backpressure, reset.
module tb_ascon_sbox_layer_dom;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  in_valid_v, rnd_valid_v, out_ready_v;
  wire  [2:0]  in_ready_v, rnd_ready_v, out_valid_v, busy_v;
  logic [1279:0] si [3];
  logic [319:0]  rw [3];
  wire  [959:0]  so0;
  wire  [639:0]  so1;
  wire  [1279:0] so2;

  int checks   = 0;
  int failures = 0;

  ascon_sbox_layer_dom #(.D(2), .LANES(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .state_in(si[0][959:0]), .rnd_valid(rnd_valid_v[0]), .rnd_ready(rnd_ready_v[0]),
    .rnd_in(rw[0][119:0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .state_out(so0), .busy(busy_v[0]));

  ascon_sbox_layer_dom #(.D(1), .LANES(64)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .state_in(si[1][639:0]), .rnd_valid(rnd_valid_v[1]), .rnd_ready(rnd_ready_v[1]),
    .rnd_in(rw[1][319:0]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .state_out(so1), .busy(busy_v[1]));

  ascon_sbox_layer_dom #(.D(3), .LANES(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .state_in(si[2][1279:0]), .rnd_valid(rnd_valid_v[2]), .rnd_ready(rnd_ready_v[2]),
    .rnd_in(rw[2][119:0]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .state_out(so2), .busy(busy_v[2]));

  typedef struct {
    logic [319:0] x;
    logic [319:0] y;
    bit           rsh;
  } vec_t;

  // Unmasked reference: whole 64-bit words, y_i = x_i ^ (~x_{i+1} & x_{i+2})
  function automatic logic [319:0] chi(input logic [319:0] x);
    logic [63:0]  w [5];
    logic [319:0] y;
    for (int i = 0; i < 5; i++) w[i] = x[64*i +: 64];
    for (int i = 0; i < 5; i++) y[64*i +: 64] = w[i] ^ (~w[(i+1)%5] & w[(i+2)%5]);
    return y;
  endfunction

  function automatic int shares(input int u);
    return (u == 0) ? 3 : (u == 1) ? 2 : 4;
  endfunction

  function automatic int exp_lat(input int u);
    return (u == 0) ? 10 : (u == 1) ? 3 : 18;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int w = 0; w < 10; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [319:0] recomb(input int u);
    logic [1279:0] d;
    logic [319:0]  acc;
    case (u)
      0:       d = 1280'(so0);
      1:       d = 1280'(so1);
      default: d = so2;
    endcase
    acc = '0;
    for (int s = 0; s < shares(u); s++) acc ^= d[320*s +: 320];
    return acc;
  endfunction

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic load(input int u, input logic [319:0] x, input bit rsh);
    logic [1279:0] v;
    logic [319:0]  acc, sh;
    v   = '0;
    acc = x;
    for (int s = 1; s < shares(u); s++) begin
      sh = rsh ? rand320() : '0;
      v[320*s +: 320] = sh;
      acc ^= sh;
    end
    v[319:0] = acc;
    si[u] = v;
  endtask

  task automatic run(input int u, input logic [319:0] x, input bit rsh, input bit zrnd,
                     input int stall_at, input int stall_len,
                     output logic [319:0] res, output int lat, output logic drain_rdy);
    int guard;
    guard = 0;
    while (!in_ready_v[u] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    load(u, x, rsh);
    in_valid_v[u] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[u] = 1'b0;
    lat = 1;
    drain_rdy = 1'b1;
    while (!out_valid_v[u] && lat < 200) begin
      rw[u] = zrnd ? '0 : rand320();
      rnd_valid_v[u] = !(lat >= stall_at && lat < stall_at + stall_len);
      drain_rdy = rnd_ready_v[u];
      @(posedge clk); #1;
      lat++;
    end
    rnd_valid_v[u] = 1'b0;
    res = recomb(u);
  endtask

  task automatic finish_out(input int u, input int hold);
    logic [319:0] r0;
    r0 = recomb(u);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 320'(out_valid_v[u]), 320'(1));
      chk("hold_state_out", recomb(u), r0);
      chk("hold_in_ready", 320'(in_ready_v[u]), 320'(0));
    end
    out_ready_v[u] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[u] = 1'b0;
    chk("post_hs_in_ready", 320'(in_ready_v[u]), 320'(1));
    chk("post_hs_out_valid", 320'(out_valid_v[u]), 320'(0));
  endtask

  localparam logic [63:0] F = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Z = 64'h0;

  initial begin
    vec_t         tbl [5];
    logic [319:0] x, res;
    int           lat;
    logic         drdy;

    tbl[0] = '{x: {Z, Z, F, Z, Z}, y: {Z, Z, F, Z, F}, rsh: 1'b0};
    tbl[1] = '{x: {Z, Z, Z, Z, Z}, y: {Z, Z, Z, Z, Z}, rsh: 1'b1};
    tbl[2] = '{x: {F, F, F, F, F}, y: {F, F, F, F, F}, rsh: 1'b1};
    tbl[3] = '{x: {Z, Z, Z, Z, F}, y: {Z, F, Z, Z, F}, rsh: 1'b1};
    tbl[4] = '{x: {Z, Z, Z, F, Z}, y: {F, Z, Z, F, Z}, rsh: 1'b1};

    rst_n = 1'b0;
    in_valid_v = '0; rnd_valid_v = '0; out_ready_v = '0;
    for (int u = 0; u < 3; u++) begin
      si[u] = '0;
      rw[u] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 320'(in_ready_v[0]), 320'(1));
    chk("rst_out_valid", 320'(out_valid_v[0]), 320'(0));
    chk("rst_rnd_ready", 320'(rnd_ready_v[0]), 320'(0));
    chk("rst_busy", 320'(busy_v[0]), 320'(0));
    chk("rst_state_out", so0[319:0] | so0[639:320] | so0[959:640], '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run(0, tbl[i].x, tbl[i].rsh, (i == 0), -1, 0, res, lat, drdy);
      chk("table_result", res, tbl[i].y);
      chk("table_latency", 320'(lat), 320'(10));
      finish_out(0, 0);
    end

    for (int n = 0; n < 200; n++) begin
      x = rand320();
      run(0, x, 1'b1, 1'b0, -1, 0, res, lat, drdy);
      chk("random_result", res, chi(x));
      chk("random_latency", 320'(lat), 320'(10));
      finish_out(0, 0);
    end

    x = rand320();
    run(0, x, 1'b1, 1'b0, 4, 3, res, lat, drdy);
    chk("stall_latency", 320'(lat), 320'(13));
    chk("stall_result", res, chi(x));
    chk("stall_drain_rnd_ready", 320'(drdy), 320'(0));
    chk("stall_done_rnd_ready", 320'(rnd_ready_v[0]), 320'(0));
    finish_out(0, 5);

    x = rand320();
    load(0, x, 1'b1);
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    rnd_valid_v[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rw[0] = rand320();
      @(posedge clk); #1;
    end
    chk("mid_run_busy", 320'(busy_v[0]), 320'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 320'(out_valid_v[0]), 320'(0));
    chk("mid_rst_busy", 320'(busy_v[0]), 320'(0));
    chk("mid_rst_in_ready", 320'(in_ready_v[0]), 320'(1));
    chk("mid_rst_rnd_ready", 320'(rnd_ready_v[0]), 320'(0));
    chk("mid_rst_state_out", so0[319:0] | so0[639:320] | so0[959:640], '0);
    rnd_valid_v[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    x = rand320();
    run(0, x, 1'b1, 1'b0, -1, 0, res, lat, drdy);
    chk("after_rst_result", res, chi(x));
    chk("after_rst_latency", 320'(lat), 320'(10));
    finish_out(0, 0);

    for (int u = 1; u < 3; u++) begin
      for (int n = 0; n < 20; n++) begin
        x = rand320();
        run(u, x, 1'b1, 1'b0, -1, 0, res, lat, drdy);
        chk("sweep_result", res, chi(x));
        chk("sweep_latency", 320'(lat), 320'(exp_lat(u)));
        finish_out(u, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
